// File: rtl/mux_4_1_pkg.sv
// Lane naming shared by the 4:1 mux slice and its users.
package mux_4_1_pkg;

  typedef enum logic [1:0] {
    LANE_0 = 2'd0,
    LANE_1 = 2'd1,
    LANE_2 = 2'd2,
    LANE_3 = 2'd3
  } lane_e;

endpackage

// File: rtl/mux_4_1_mux_2_1.sv
// 2:1 leaf selector; element 0 of load sits in the LSBs.
module mux_2_1 #(
  parameter int WIDTH = 1
) (
  input  logic                 select,
  input  logic [2*WIDTH-1:0]   load,
  output logic [WIDTH-1:0]     data
);

  // An X/Z select is left to ordinary ternary semantics rather than masked.
  assign data = select ? load[WIDTH +: WIDTH] : load[0 +: WIDTH];

endmodule

// File: rtl/mux_4_1.sv
// 4:1 lane selector built from three 2:1 leaves, with a zero-latency
// combinational output and a one-cycle registered copy qualified by in_valid.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           inputSelect,
  input  logic [4*WIDTH-1:0]   loadbits,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     outData,
  output logic [WIDTH-1:0]     outData_q,
  output logic                 out_valid
);

  localparam int LANES = 4;
  localparam int SEL_W = $clog2(LANES);

  logic [SEL_W-1:0]       w_sel;
  logic [LANES*WIDTH-1:0] w_lanes;
  logic [WIDTH-1:0]       w_pair_lo;
  logic [WIDTH-1:0]       w_pair_hi;
  logic [WIDTH-1:0]       w_selected;
  logic [WIDTH-1:0]       r_data;
  logic                   r_valid;

  assign w_sel   = inputSelect;
  assign w_lanes = loadbits;

  // Level 1 resolves select bit 0 within each lane pair; level 2 picks the pair.
  mux_2_1 #(.WIDTH(WIDTH)) u_lvl1_lo (
    .select (w_sel[0]),
    .load   (w_lanes[0 +: 2*WIDTH]),
    .data   (w_pair_lo)
  );

  mux_2_1 #(.WIDTH(WIDTH)) u_lvl1_hi (
    .select (w_sel[0]),
    .load   (w_lanes[2*WIDTH +: 2*WIDTH]),
    .data   (w_pair_hi)
  );

  mux_2_1 #(.WIDTH(WIDTH)) u_lvl2 (
    .select (w_sel[1]),
    .load   ({w_pair_hi, w_pair_lo}),
    .data   (w_selected)
  );

  assign outData = w_selected;

  // Capture stage: reset wins, idle cycles hold data but drop valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (in_valid) begin
      r_data  <= w_selected;
      r_valid <= 1'b1;
    end else begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end
  end

  assign outData_q = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_4_1.sv
// Directed plus randomized check of mux_4_1 at WIDTH=1 and WIDTH=8
// against a shift-based lane model.
module tb_mux_4_1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  sel1;
  logic [1:0]  sel8;
  logic [3:0]  lb1;
  logic [31:0] lb8;
  logic        out1;
  logic        out1_q;
  logic        out1_v;
  logic [7:0]  out8;
  logic [7:0]  out8_q;
  logic        out8_v;

  int n_chk;
  int n_fail;

  // Model state for the registered path.
  logic [7:0] eq8;
  logic       ev8;
  logic       eq1;
  logic       ev1;

  logic [7:0] seq_exp [4];
  logic [3:0] pat;

  mux_4_1 #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .inputSelect (sel1),
    .loadbits    (lb1),
    .in_valid    (in_valid),
    .outData     (out1),
    .outData_q   (out1_q),
    .out_valid   (out1_v)
  );

  mux_4_1 #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .inputSelect (sel8),
    .loadbits    (lb8),
    .in_valid    (in_valid),
    .outData     (out8),
    .outData_q   (out8_q),
    .out_valid   (out8_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane8(input logic [31:0] lb, input logic [1:0] s);
    return 8'((lb >> (int'(s) * 8)) & 32'hFF);
  endfunction

  function automatic logic lane1(input logic [3:0] lb, input logic [1:0] s);
    return 1'((lb >> int'(s)) & 4'h1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, applying the register rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      eq8 = 8'h00; ev8 = 1'b0; eq1 = 1'b0; ev1 = 1'b0;
    end else if (in_valid) begin
      eq8 = lane8(lb8, sel8); ev8 = 1'b1;
      eq1 = lane1(lb1, sel1); ev1 = 1'b1;
    end else begin
      ev8 = 1'b0; ev1 = 1'b0;
    end
    #1;
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, "_q8"}, 32'(out8_q), 32'(eq8));
    chk({tag, "_v8"}, 32'(out8_v), 32'(ev8));
    chk({tag, "_q1"}, 32'(out1_q), 32'(eq1));
    chk({tag, "_v1"}, 32'(out1_v), 32'(ev1));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    eq8 = 8'h00; ev8 = 1'b0; eq1 = 1'b0; ev1 = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1;
    sel1 = 2'd0; sel8 = 2'd0; lb1 = 4'h0; lb8 = 32'h0;
    seq_exp[0] = 8'h01; seq_exp[1] = 8'h5A; seq_exp[2] = 8'hC3; seq_exp[3] = 8'hFA;

    // Reset state, with in_valid high to show reset priority.
    lb8 = 32'h1234_5678;
    tick(); tick();
    chk("rst_q8", 32'(out8_q), 32'h0);
    chk("rst_v8", 32'(out8_v), 32'h0);
    chk("rst_q1", 32'(out1_q), 32'h0);
    chk("rst_v1", 32'(out1_v), 32'h0);
    // Combinational path keeps working under reset.
    for (int s = 0; s < 4; s++) begin
      sel8 = 2'(s);
      #1;
      chk("rst_comb8", 32'(out8), 32'(lane8(lb8, sel8)));
    end

    // All-zero then all-one lanes.
    for (int s = 0; s < 4; s++) begin
      lb1 = 4'b0000; sel1 = 2'(s); #1;
      chk("const0", 32'(out1), 32'h0);
    end
    for (int s = 0; s < 4; s++) begin
      lb1 = 4'b1111; sel1 = 2'(s); #1;
      chk("const1", 32'(out1), 32'h1);
    end

    // Alternating patterns with fixed expectations.
    pat = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      lb1 = 4'hA; sel1 = 2'(s); #1;
      chk("patA", 32'(out1), 32'(pat[s]));
    end
    pat = 4'b0101;
    for (int s = 0; s < 4; s++) begin
      lb1 = 4'h5; sel1 = 2'(s); #1;
      chk("pat5", 32'(out1), 32'(pat[s]));
    end

    // Exhaustive WIDTH=1 combinational sweep.
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        lb1 = 4'(v); sel1 = 2'(s); #1;
        chk("sweep", 32'(out1), 32'(lane1(lb1, sel1)));
      end
    end

    // Back-to-back registered stream.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; lb8 = 32'hFAC3_5A01;
    for (int s = 0; s < 4; s++) begin
      sel8 = 2'(s);
      tick();
      chk("stream_q", 32'(out8_q), 32'(seq_exp[s]));
      chk("stream_v", 32'(out8_v), 32'h1);
    end

    // Reset mid-stream, then idle hold, then recovery.
    sel8 = 2'd1;
    tick();
    chk("pre_rst_q", 32'(out8_q), 32'h5A);
    rst_n = 1'b0; sel8 = 2'd2;
    tick();
    chk("mid_rst_q", 32'(out8_q), 32'h00);
    chk("mid_rst_v", 32'(out8_v), 32'h0);
    chk("mid_rst_comb", 32'(out8), 32'hC3);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("idle_q", 32'(out8_q), 32'h00);
    chk("idle_v", 32'(out8_v), 32'h0);
    in_valid = 1'b1; sel8 = 2'd3;
    tick();
    chk("recover_q", 32'(out8_q), 32'hFA);
    chk("recover_v", 32'(out8_v), 32'h1);
    in_valid = 1'b0; sel8 = 2'd0;
    tick();
    chk("hold_q", 32'(out8_q), 32'hFA);
    chk("hold_v", 32'(out8_v), 32'h0);
    // Between-edge changes must not reach the register.
    sel8 = 2'd2; lb8 = 32'h0000_0000; #2;
    chk("between_q", 32'(out8_q), 32'hFA);
    chk("between_comb", 32'(out8), 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rst_n    = ($urandom_range(0, 19) != 0);
      in_valid = 1'($urandom);
      sel1     = 2'($urandom);
      sel8     = 2'($urandom);
      lb1      = 4'($urandom);
      lb8      = $urandom;
      #1;
      chk("rnd_comb8", 32'(out8), 32'(lane8(lb8, sel8)));
      chk("rnd_comb1", 32'(out1), 32'(lane1(lb1, sel1)));
      tick();
      chk_reg("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4_1.md
MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data lane.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 inputSelect  input  2  lane select; value i selects lane i.
REQ-005 loadbits  input  4*WIDTH  four packed lanes; lane i = loadbits[i*WIDTH +: WIDTH], lane 0 in LSBs.
REQ-006 in_valid  input  1  qualifies inputSelect/loadbits for the registered path.
REQ-007 outData  output  WIDTH  combinational selected lane, zero latency.
REQ-008 outData_q  output  WIDTH  registered selected lane.
REQ-009 out_valid  output  1  outData_q holds a sample captured with in_valid=1.

Function
REQ-010 outData SHALL equal lane[inputSelect] combinationally for every select value 0..3, independent of clk and rst_n.
REQ-011 outData SHALL be built as a two-level mux_2_1 tree: level 1 uses inputSelect[0] on lane pairs (0,1) and (2,3); level 2 uses inputSelect[1] on the two level-1 results.
REQ-012 mux_2_1 SHALL drive data = load[1] when select=1, else load[0]; ports: select (1), load (2*WIDTH, element 0 in LSBs), data (WIDTH).
REQ-013 On a rising clk with rst_n=1 and in_valid=1: outData_q <= lane[inputSelect], out_valid <= 1; latency exactly one cycle.
REQ-014 On a rising clk with rst_n=1 and in_valid=0: outData_q SHALL hold its value; out_valid <= 0.
REQ-015 No handshake back-pressure; every valid input is accepted, one per cycle, back-to-back.
REQ-016 Select or data changes between edges SHALL affect only outData, never outData_q, until the next qualifying edge.
REQ-017 X/Z on any select bit SHALL NOT be masked; propagation follows standard RTL semantics.
REQ-018 No arithmetic; widths are exact, no truncation or extension.

Reset
REQ-019 On a rising clk with rst_n=0: outData_q <= 0, out_valid <= 0; reset takes priority over in_valid.
REQ-020 Reset SHALL NOT affect outData; combinational selection continues during reset.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight sample; first valid output after release appears one cycle after the first in_valid=1 edge.

Structure
REQ-022 mux_2_1 SHALL be the sole sub-module, instantiated three times with WIDTH propagated.
REQ-023 No shared package is required; the lane count (4) and select width (2) SHALL be local constants.
REQ-024 With WIDTH=1 and registered ports unconnected, mux_4_1 SHALL be a drop-in leaf for larger mux trees (e.g. eight leaves plus two second-level leaves plus one mux_2_1 form a 32:1 mux).

Verification
REQ-025 WIDTH=1, loadbits=4'b0000, then 4'b1111, inputSelect swept 0..3 -> outData constant 0, then constant 1.
REQ-026 WIDTH=1, loadbits=4'hA, inputSelect 0,1,2,3 -> outData 0,1,0,1; with 4'h5 -> 1,0,1,0.
REQ-027 WIDTH=1, loadbits swept 0..15, exhaustive select -> outData == loadbits[inputSelect] on every combination.
REQ-028 WIDTH=8, loadbits=32'hFAC3_5A01, in_valid=1, select 0,1,2,3 on consecutive edges -> outData_q 8'h01,8'h5A,8'hC3,8'hFA one cycle later each; out_valid high throughout.
REQ-029 rst_n=0 for one edge mid-stream -> outData_q=0, out_valid=0 next cycle while outData still tracks select; in_valid=0 afterwards -> outData_q holds, out_valid=0.
